// File: rtl/bsr_universal.sv
// ---------------------------------------------------------------------------
// bsr_universal
//   Universal bidirectional shift register. It supports logical shift left and
//   right, rotate left and right, arithmetic shift right, parallel load and
//   synchronous clear. A frame counter counts consecutive shifts of the same
//   kind and pulses done once for every WIDTH such shifts.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active low
//   en    : operation enable; when low, all state holds and done is 0
//   mode  : operation select (HOLD/SHL/SHR/ROL/ROR/ASR/LOAD/CLR)
//   sin   : serial data input
//   pin   : parallel load data
//   pout  : register contents
//   sout  : registered copy of the bit most recently shifted or rotated out
//   cnt   : number of shifts completed in the current frame
//   done  : one-cycle pulse when a frame of WIDTH shifts completes
// ---------------------------------------------------------------------------
module bsr_universal #(
   parameter  int WIDTH = 4,
   localparam int CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] pout,
   output logic             sout,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_SHL  = 3'b001,
      M_SHR  = 3'b010,
      M_ROL  = 3'b011,
      M_ROR  = 3'b100,
      M_ASR  = 3'b101,
      M_LOAD = 3'b110,
      M_CLR  = 3'b111
   } mode_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   mode_t            mode_op;
   logic [WIDTH-1:0] q, q_nxt;
   logic             sout_r, sout_nxt;
   logic [CW-1:0]    cnt_r, cnt_nxt;
   mode_t            last_mode, last_mode_nxt;
   logic             done_r, done_nxt;
   logic             is_shift;

   assign mode_op = mode_t'(mode);

   always_comb begin
      q_nxt         = q;
      sout_nxt      = sout_r;
      cnt_nxt       = cnt_r;
      last_mode_nxt = last_mode;
      done_nxt      = 1'b0;
      is_shift      = 1'b0;

      if (en) begin
         unique case (mode_op)
            M_SHL: begin
               q_nxt    = {q[WIDTH-2:0], sin};
               sout_nxt = q[WIDTH-1];
               is_shift = 1'b1;
            end
            M_SHR: begin
               q_nxt    = {sin, q[WIDTH-1:1]};
               sout_nxt = q[0];
               is_shift = 1'b1;
            end
            M_ROL: begin
               q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
               sout_nxt = q[WIDTH-1];
               is_shift = 1'b1;
            end
            M_ROR: begin
               q_nxt    = {q[0], q[WIDTH-1:1]};
               sout_nxt = q[0];
               is_shift = 1'b1;
            end
            M_ASR: begin
               q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
               sout_nxt = q[0];
               is_shift = 1'b1;
            end
            M_LOAD: begin
               q_nxt         = pin;
               sout_nxt      = 1'b0;
               cnt_nxt       = '0;
               last_mode_nxt = M_HOLD;
            end
            M_CLR: begin
               q_nxt         = '0;
               sout_nxt      = 1'b0;
               cnt_nxt       = '0;
               last_mode_nxt = M_HOLD;
            end
            default: begin
            end
         endcase
      end

      // A change of shift kind starts a new frame with this shift as the first.
      if (is_shift) begin
         last_mode_nxt = mode_op;
         if (mode_op != last_mode) begin
            cnt_nxt = CW'(1);
         end else if (cnt_r == CNT_LAST) begin
            cnt_nxt  = '0;
            done_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt_r + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q         <= '0;
         sout_r    <= 1'b0;
         cnt_r     <= '0;
         last_mode <= M_HOLD;
         done_r    <= 1'b0;
      end else begin
         q         <= q_nxt;
         sout_r    <= sout_nxt;
         cnt_r     <= cnt_nxt;
         last_mode <= last_mode_nxt;
         done_r    <= done_nxt;
      end
   end

   assign pout = q;
   assign sout = sout_r;
   assign cnt  = cnt_r;
   assign done = done_r;

endmodule

// File: tb/tb_bsr_universal.sv
module tb_bsr_universal;
   localparam int W  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic [2:0]    mode = 3'b000;
   logic          sin = 1'b0;
   logic [W-1:0]  pin = '0;
   logic [W-1:0]  pout;
   logic          sout;
   logic [CW-1:0] cnt;
   logic          done;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   // reference model state: register value as an integer, and the run length
   // of consecutive shifts of the same kind since the last mode change
   int mq = 0, msout = 0, mrun = 0, mlast = 0, mdone = 0;

   bsr_universal #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pin(pin),
      .pout(pout), .sout(sout), .cnt(cnt), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      int full, top, bot;
      if (!rst) begin
         mq = 0; msout = 0; mrun = 0; mlast = 0; mdone = 0;
      end else begin
         full  = 1 << W;
         top   = (mq >> (W - 1)) & 1;
         bot   = mq & 1;
         mdone = 0;
         if (en) begin
            case (int'(mode))
               1: begin msout = top; mq = (mq * 2 + int'(sin)) % full; end
               2: begin msout = bot; mq = mq / 2 + int'(sin) * (full / 2); end
               3: begin msout = top; mq = (mq * 2 + top) % full; end
               4: begin msout = bot; mq = mq / 2 + bot * (full / 2); end
               5: begin msout = bot; mq = mq / 2 + top * (full / 2); end
               6: begin mq = int'(pin); msout = 0; mrun = 0; mlast = 0; end
               7: begin mq = 0; msout = 0; mrun = 0; mlast = 0; end
               default: ;
            endcase
            if (mode >= 3'd1 && mode <= 3'd5) begin
               if (int'(mode) != mlast) mrun = 1;
               else mrun = mrun + 1;
               mlast = int'(mode);
               if (mrun % W == 0) mdone = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_pout", int'(pout), mq);
         chk("model_sout", int'(sout), msout);
         chk("model_cnt",  int'(cnt),  mrun % W);
         chk("model_done", int'(done), mdone);
      end
   end

   // apply inputs, then return 2 time units after the edge that consumed them
   task automatic step(input logic e, input logic [2:0] m, input logic s,
                       input logic [W-1:0] p);
      en = e; mode = m; sin = s; pin = p;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] exp_p1[4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
      logic [3:0] exp_p3[4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
      int         exp_s3[4] = '{1, 0, 0, 1};
      logic [2:0] rmode;

      #3;
      chk("reset_pout", int'(pout), 0);
      chk("reset_cnt",  int'(cnt),  0);
      chk("reset_done", int'(done), 0);
      #9;
      rst = 1'b1;
      chk_on = 1'b1;

      // 1: SHL with sin 1,0,1,0
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'b001, (i % 2 == 0), '0);
         chk("t1_pout", int'(pout), int'(exp_p1[i]));
         chk("t1_sout", int'(sout), 0);
         chk("t1_cnt",  int'(cnt),  (i + 1) % 4);
         chk("t1_done", int'(done), (i == 3) ? 1 : 0);
      end

      // 2: LOAD 1000, ASR x3
      step(1'b1, 3'b110, 1'b0, 4'b1000);
      chk("t2_load", int'(pout), 8);
      chk("t2_cnt0", int'(cnt), 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 3'b101, 1'b1, '0);
         chk("t2_pout", int'(pout), (i == 0) ? 12 : (i == 1) ? 14 : 15);
         chk("t2_cnt",  int'(cnt),  i + 1);
         chk("t2_done", int'(done), 0);
      end

      // 3: LOAD 1001, ROL x4
      step(1'b1, 3'b110, 1'b0, 4'b1001);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'b011, 1'b0, '0);
         chk("t3_pout", int'(pout), int'(exp_p3[i]));
         chk("t3_sout", int'(sout), exp_s3[i]);
         chk("t3_done", int'(done), (i == 3) ? 1 : 0);
      end

      // 4: SHL x2 then SHR restarts the frame
      step(1'b1, 3'b001, 1'b0, '0);
      step(1'b1, 3'b001, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'b010, 1'b1, '0);
         chk("t4_cnt",  int'(cnt),  (i + 1) % 4);
         chk("t4_done", int'(done), (i == 3) ? 1 : 0);
      end

      // 5: frame survives HOLD and en=0
      step(1'b1, 3'b111, 1'b0, '0);
      step(1'b1, 3'b001, 1'b1, '0);
      step(1'b1, 3'b001, 1'b1, '0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 3'b000, 1'b0, '0);
         chk("t5_hold_pout", int'(pout), 3);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 3'b001, 1'b0, '0);
         chk("t5_en0_pout", int'(pout), 3);
         chk("t5_en0_cnt",  int'(cnt),  2);
      end
      step(1'b1, 3'b001, 1'b0, '0);
      chk("t5_done3", int'(done), 0);
      step(1'b1, 3'b001, 1'b0, '0);
      chk("t5_done4", int'(done), 1);
      chk("t5_pout",  int'(pout), 12);

      // 6: async reset between edges, then CLR from 1010
      step(1'b1, 3'b010, 1'b1, '0);
      step(1'b1, 3'b010, 1'b1, '0);
      rst = 1'b0;
      #1;
      chk("t6_rst_pout", int'(pout), 0);
      chk("t6_rst_cnt",  int'(cnt),  0);
      chk("t6_rst_sout", int'(sout), 0);
      chk("t6_rst_done", int'(done), 0);
      #1;
      rst = 1'b1;
      step(1'b1, 3'b110, 1'b0, 4'b1010);
      chk("t6_load", int'(pout), 10);
      step(1'b1, 3'b111, 1'b0, '0);
      chk("t6_clr", int'(pout), 0);

      // randomized: sticky modes so frames complete, occasional async resets
      rmode = 3'b001;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 4) == 0) rmode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 79) == 0) begin
            rst = 1'b0;
            #1;
            rst = 1'b1;
         end
         step($urandom_range(0, 7) != 0, rmode, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
